// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants for the MIPS-like front end.
// Contents:
//   - opcode and funct values the PC logic decodes
//   - trap link register numbers (k0 = 26 for interrupts, k1 = 27 for
//     exceptions)
//   - default reset, interrupt and exception vectors
//   - helper that identifies the conditional branch opcodes
// ---------------------------------------------------------------------------
package mips_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_SPECIAL = 6'd0;
    localparam logic [5:0] OP_REGIMM  = 6'd1;   // bltz family
    localparam logic [5:0] OP_J       = 6'd2;
    localparam logic [5:0] OP_JAL     = 6'd3;
    localparam logic [5:0] OP_BEQ     = 6'd4;
    localparam logic [5:0] OP_BNE     = 6'd5;
    localparam logic [5:0] OP_BLEZ    = 6'd6;
    localparam logic [5:0] OP_BGTZ    = 6'd7;

    // SPECIAL funct codes, instr[5:0]
    localparam logic [5:0] FUNCT_JR   = 6'd8;
    localparam logic [5:0] FUNCT_JALR = 6'd9;

    // Trap link registers
    localparam logic [4:0] REG_K0 = 5'd26;  // interrupt return address
    localparam logic [4:0] REG_K1 = 5'd27;  // exception return address

    // Vector defaults; bit 31 set means the handler runs in kernel mode
    localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0008;

    // True for every opcode whose target is pc-relative and conditional
    function automatic logic is_cond_branch(input logic [5:0] op);
        return (op == OP_REGIMM) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_BLEZ)   || (op == OP_BGTZ);
    endfunction

endpackage

// File: rtl/pc_next.sv
// ---------------------------------------------------------------------------
// pc_next
// Purely combinational next-address calculation for the normal
// (non-trap) flow.
// Ports:
//   i_pc           in  32  current pc; bit 31 = kernel mode
//   i_instr        in  32  current instruction word
//   i_branch_taken in   1  datapath compare result for a conditional branch
//   i_rs_data      in  32  rs register value for jr/jalr
//   o_pc_plus4     out 32  sequential address / link value
//   o_target       out 32  address the pc moves to when no trap is taken
// ---------------------------------------------------------------------------
module pc_next
    import mips_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic        i_branch_taken,
    input  logic [31:0] i_rs_data,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_target
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [30:0] w_offset;
    logic [31:0] w_pc_plus4;

    assign w_op    = i_instr[31:26];
    assign w_funct = i_instr[5:0];

    // The mode bit is never touched by the adder: the low 31 bits wrap
    // on their own so user code cannot walk into kernel space.
    assign w_pc_plus4 = {i_pc[31], i_pc[30:0] + 31'd4};
    assign o_pc_plus4 = w_pc_plus4;

    // Sign-extended word offset, truncated to the 31-bit address space
    assign w_offset = {{13{i_instr[15]}}, i_instr[15:0], 2'b00};

    always_comb begin
        o_target = w_pc_plus4;
        if ((w_op == OP_J) || (w_op == OP_JAL)) begin
            o_target = {w_pc_plus4[31:28], i_instr[25:0], 2'b00};
        end else if (is_cond_branch(w_op)) begin
            if (i_branch_taken) begin
                o_target = {i_pc[31], w_pc_plus4[30:0] + w_offset};
            end
        end else if ((w_op == OP_SPECIAL) &&
                     ((w_funct == FUNCT_JR) || (w_funct == FUNCT_JALR))) begin
            // A register jump may drop to user mode but can only stay in
            // kernel mode if it was already there.
            o_target = {i_pc[31] & i_rs_data[31], i_rs_data[30:0]};
        end
    end

endmodule

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program counter register plus trap sequencing (reset, undefined
// instruction exception, timer interrupt).
// Ports:
//   clk          in  1   rising-edge clock
//   reset        in  1   synchronous active-high reset
//   instr        in  32  current instruction word
//   branch_taken in  1   compare result for the current branch
//   rs_data      in  32  rs value for jr/jalr
//   irq          in  1   level interrupt request
//   undef        in  1   current instruction is illegal
//   pc           out 32  current pc; bit 31 = kernel mode
//   rom_addr     out 31  instruction ROM address (pc[30:0])
//   pc_plus4     out 32  link value for jal/jalr
//   kill         out 1   suppress writes of the current instruction
//   xp_we        out 1   write trap return address to the regfile
//   xp_waddr     out 5   trap link register number
//   xp_wdata     out 32  trap return address
//   int_ack      out 1   interrupt taken this cycle
// All outputs except pc are combinational.
// ---------------------------------------------------------------------------
module pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [31:0] IRQ_VEC   = DEF_IRQ_VEC,
    parameter logic [31:0] EXC_VEC   = DEF_EXC_VEC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic [31:0] rs_data,
    input  logic        irq,
    input  logic        undef,
    output logic [31:0] pc,
    output logic [30:0] rom_addr,
    output logic [31:0] pc_plus4,
    output logic        kill,
    output logic        xp_we,
    output logic [4:0]  xp_waddr,
    output logic [31:0] xp_wdata,
    output logic        int_ack
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic [31:0] w_pc_next;
    logic        w_take_exc;
    logic        w_take_irq;

    pc_next u_pc_next (
        .i_pc           (r_pc),
        .i_instr        (instr),
        .i_branch_taken (branch_taken),
        .i_rs_data      (rs_data),
        .o_pc_plus4     (w_pc_plus4),
        .o_target       (w_target)
    );

    // Exceptions are taken in any mode; interrupts only from user mode,
    // and never alongside an exception.
    assign w_take_exc = undef;
    assign w_take_irq = irq & ~r_pc[31] & ~undef;

    always_comb begin
        w_pc_next = w_target;
        kill      = 1'b0;
        xp_we     = 1'b0;
        xp_waddr  = 5'd0;
        xp_wdata  = 32'd0;
        int_ack   = 1'b0;
        if (reset) begin
            // Hold off side effects of whatever is on the instruction bus
            w_pc_next = RESET_VEC;
            kill      = 1'b1;
        end else if (w_take_exc) begin
            w_pc_next = EXC_VEC;
            kill      = 1'b1;
            xp_we     = 1'b1;
            xp_waddr  = REG_K1;
            xp_wdata  = {1'b0, w_pc_plus4[30:0]};
        end else if (w_take_irq) begin
            // Link the interrupted pc itself so that instruction re-executes
            w_pc_next = IRQ_VEC;
            kill      = 1'b1;
            xp_we     = 1'b1;
            xp_waddr  = REG_K0;
            xp_wdata  = r_pc;
            int_ack   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc       = r_pc;
    assign rom_addr = r_pc[30:0];
    assign pc_plus4 = w_pc_plus4;

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h8000_0000, power-on/reset fetch address.
REQ-002 SHALL have parameter IRQ_VEC, default 32'h8000_0004, interrupt handler entry.
REQ-003 SHALL have parameter EXC_VEC, default 32'h8000_0008, undefined-instruction handler entry.
REQ-004 SHALL have ports: clk  in  1  rising-edge clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports: reset  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: instr  in  32  current instruction word from instruction ROM.
REQ-007 SHALL have ports: branch_taken  in  1  datapath compare result for the current branch.
REQ-008 SHALL have ports: rs_data  in  32  register rs value for jr/jalr.
REQ-009 SHALL have ports: irq  in  1  level interrupt request from timer.
REQ-010 SHALL have ports: undef  in  1  decoder flags current instr as illegal.
REQ-011 SHALL have ports: pc  out  32  current PC; bit 31 = kernel mode.
REQ-012 SHALL have ports: rom_addr  out  31  pc[30:0] to instruction ROM.
REQ-013 SHALL have ports: pc_plus4  out  32  link value for jal/jalr.
REQ-014 SHALL have ports: kill  out  1  suppress regfile/memory writes of current instruction.
REQ-015 SHALL have ports: xp_we  out  1  write return address to regfile; xp_waddr  out  5; xp_wdata  out  32.
REQ-016 SHALL have ports: int_ack  out  1  one-cycle pulse when interrupt is taken.

Function
REQ-017 SHALL update pc on every rising clk edge; all outputs except pc are combinational from pc, instr and inputs.
REQ-018 SHALL compute pc_plus4 = {pc[31], pc[30:0]+4}; 31-bit wrap, bit 31 never changed by addition.
REQ-019 SHALL, for j/jal (op 2/3), select {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-020 SHALL, for beq/bne/blez/bgtz/bltz (op 4/5/6/7/1) with branch_taken=1, select {pc[31], pc_plus4[30:0] + (sext(instr[15:0])<<2)[30:0]}; branch_taken=0 selects pc_plus4.
REQ-021 SHALL, for jr/jalr (op 0, funct 8/9), select {pc[31] & rs_data[31], rs_data[30:0]}: jr may leave kernel mode, never enter it.
REQ-022 SHALL otherwise select pc_plus4.
REQ-023 SHALL take exception when undef=1 (any mode): next pc=EXC_VEC, kill=1, xp_we=1, xp_waddr=27, xp_wdata=pc_plus4 with bit 31 cleared.
REQ-024 SHALL take interrupt when irq=1, pc[31]=0, undef=0: next pc=IRQ_VEC, kill=1, xp_we=1, xp_waddr=26, xp_wdata=pc (interrupted instruction re-executes), int_ack=1.
REQ-025 SHALL ignore irq while pc[31]=1; a still-asserted irq is taken on the first user-mode cycle after return.
REQ-026 SHALL give priority exception > interrupt > normal flow; simultaneous undef and irq yields exception only, int_ack=0.
REQ-027 SHALL hold kill=0, xp_we=0, int_ack=0 when no trap is taken.

Reset
REQ-028 SHALL load pc=RESET_VEC on a clk edge with reset=1, overriding every other input.
REQ-029 SHALL drive kill=1, xp_we=0, int_ack=0 while reset=1.
REQ-030 SHALL resume at RESET_VEC on the first edge after reset deasserts, including reset asserted mid-handler.

Structure
REQ-031 SHALL take opcode/funct constants, register numbers 26/27 and vector defaults from shared package mips_pkg.
REQ-032 SHALL contain one combinational sub-module pc_next (target calculation, REQ-018..022); trap priority and the pc register stay in pc_unit.

Verification
REQ-033 SHALL test reset: reset=1 two cycles -> pc=0x8000_0000, rom_addr=0x0000_0000, kill=1; release -> pc=0x8000_0004 after j 0x0000003 fetched? no: instr 0x08000003 -> pc=0x8000_000C.
REQ-034 SHALL test branch: pc=0x0000_0080, instr 0x1120FFFD, branch_taken=1 -> pc=0x0000_0078; branch_taken=0 -> 0x0000_0084.
REQ-035 SHALL test interrupt: pc=0x0000_0050, irq=1 -> int_ack=1, xp_waddr=26, xp_wdata=0x0000_0050, kill=1, next pc=0x8000_0004; in kernel irq=1 -> no trap.
REQ-036 SHALL test return: pc=0x8000_0248, instr jr $26 (0x03400008), rs_data=0x0000_0050 -> pc=0x0000_0050; rs_data=0x8000_0100 from user mode -> pc=0x0000_0100.
REQ-037 SHALL test exception priority: pc=0x0000_0040, undef=1, irq=1 -> xp_waddr=27, xp_wdata=0x0000_0044, int_ack=0, pc=0x8000_0008.
REQ-038 SHALL test wrap: pc=0x7FFF_FFFC, plain instr -> pc=0x0000_0000, bit 31 stays 0.
